result_readback_buffer: RTL
===========================

# result_readback_buffer

Buffers result words produced by the timing controller (DDS readback, loop-back, SPI results) and presents them to the bus-side reader through a valid/ready handshake. It sits directly downstream of the timing controller's `result_data`/`result_wr_en` port and upstream of the AXI read path. Words are never back-pressured into the timing controller. If the buffer is full, the incoming word is dropped and the drop is recorded in sticky overflow status.

## Interface
- `DEPTH`, 64: number of entries; power of two, 4..1024.
- `RESULT_WIDTH`, 32: width of result and read words.
- `CNT_WIDTH`, 16: width of the saturating drop counter.

- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `init`  in  1  synchronous flush; same effect as reset, but takes effect at the clock edge.
- `result_data`  in  RESULT_WIDTH  producer word; valid only while `result_wr_en` is high.
- `result_wr_en`  in  1  one word per high cycle; no ready is returned.
- `rd_data`  out  RESULT_WIDTH  head word.
- `rd_valid`  out  1  `rd_data` is valid.
- `rd_ready`  in  1  consumer accepts the word.
- `rd_last`  out  1  current word is the final word of its entry.
- `level`  out  $clog2(DEPTH)+1  number of stored entries.
- `overflow`  out  1  sticky; set by any dropped word.
- `drop_count`  out  CNT_WIDTH  number of dropped words, saturating.
- `clear_overflow`  in  1  clears `overflow` and `drop_count`.

## Operation
- Reset values: `rd_data`=0, `rd_valid`=0, `rd_last`=0, `level`=0, `overflow`=0, `drop_count`=0. Pointers are 0.
- `init` high: same clear as reset at the next edge. A write or read in that cycle is ignored.
- Push:
  - When `result_wr_en` is high and the buffer is not full, the word is stored at the write pointer and the pointer advances.
  - Pointers wrap modulo DEPTH.
- Drop:
  - When `result_wr_en` is high and the buffer is full with no pop in the same cycle, the word is discarded.
  - `overflow` is set to 1.
  - `drop_count` increments and stops at all-ones.
- Pop: a transfer occurs when `rd_valid` and `rd_ready` are both high on a clock edge.
- Push and pop in the same cycle:
  - The push is always accepted, including when the buffer is full; the pop frees the slot.
  - `level` is unchanged.
- Push while empty: the word appears on the read side per the latency rule in Timing.
- `clear_overflow` together with a drop in the same cycle: the drop wins. `overflow`=1 and `drop_count`=1.
- `level` counts whole entries. It decrements on the pop of an entry's `rd_last` word.
- Read-side FSM:
  - States are IDLE, DATA and TS; TS exists only when the feature described under Configuration is compiled in.
  - IDLE → DATA when an entry is present.
  - DATA → (pop) → TS, when the feature is enabled.
  - DATA or TS → (pop of last word) → DATA if another entry is present, otherwise IDLE.

## Timing
- Write-to-read latency:
  - A word pushed at edge N into an empty buffer gives `rd_valid`=1 after edge N+1.
  - The output is registered, first-word-fall-through.
- Throughput:
  - One word per cycle on both sides.
  - Back-to-back pops with `rd_ready` held high produce a word every cycle with no bubbles while the buffer holds data.
- Handshake rules:
  - `rd_data` and `rd_last` stay stable while `rd_valid`=1 and `rd_ready`=0.
  - `rd_valid` never drops without a transfer, except on reset or `init`.
- `level` and `overflow` update at the same edge as the push or pop that changes them.
- Reset mid-transfer: all outputs clear immediately (asynchronous). A partially read entry is lost.

## Configuration
- `RESULT_TIMESTAMP_EN` defined:
  - A free-running RESULT_WIDTH-bit cycle counter runs; it is cleared by reset or `init` and wraps.
  - Each push stores {timestamp at push edge, data}.
  - The reader emits the data word (`rd_last`=0), then the timestamp word (`rd_last`=1).
  - One entry uses two pops.
- `RESULT_TIMESTAMP_EN` undefined:
  - No counter and no TS state.
  - Entries are a single word; `rd_last`=1 whenever `rd_valid`=1.

## Structure
- Package `result_buffer_pkg`:
  - read FSM state enum;
  - `RESULT_WIDTH` default;
  - entry struct typedef with fields data and, when enabled, timestamp.
- Sub-module `result_buffer_ram`: a simple dual-port DEPTH×entry-width RAM with a registered read port, inferrable as block RAM.
- The top level holds the pointers, `level`, drop logic, read FSM and output register.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles with `rd_ready`=1:
  - `rd_valid` rises one cycle after the first push;
  - reads return 0x11, 0x22, 0x33 back-to-back;
  - `level` ends at 0.
- Fill 64 entries with `rd_ready`=0, then push 0xDEAD twice:
  - `level`=64, `overflow`=1, `drop_count`=2;
  - draining yields the original 64 words only.
- Full buffer, push 0xBEEF with a pop in the same cycle: no drop, `level` stays 64, and 0xBEEF is read last.
- `rd_ready` toggling 1/0 during a drain: `rd_data` holds while stalled, with no duplicated or missing words.
- `clear_overflow` together with a dropped push: `overflow`=1 and `drop_count`=1. Then `init`: all outputs are 0 and `level`=0.
- With `RESULT_TIMESTAMP_EN`, two pushes 5 cycles apart:
  - reads are data0 (`rd_last`=0), ts0, data1, ts1;
  - ts1−ts0=5.

Source files
------------

// File: rtl/result_readback_buffer_pkg.sv
// Shared types for the result readback buffer.
// RESULT_TIMESTAMP_EN adds the timestamp word and the TS read state.
package result_buffer_pkg;

  localparam int RESULT_WIDTH_DEF = 32;

`ifdef RESULT_TIMESTAMP_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_TS
  } rd_state_e;

  typedef struct packed {
    logic [RESULT_WIDTH_DEF-1:0] ts;
    logic [RESULT_WIDTH_DEF-1:0] data;
  } result_entry_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA
  } rd_state_e;

  typedef struct packed {
    logic [RESULT_WIDTH_DEF-1:0] data;
  } result_entry_t;
`endif

  function automatic int entry_width(int w);
`ifdef RESULT_TIMESTAMP_EN
    return 2 * w;
`else
    return w;
`endif
  endfunction

endpackage

// File: rtl/result_readback_buffer_if.sv
// Producer push port and reader valid/ready port of the buffer.
// master = producer/reader side, slave = the buffer.
interface result_readback_buffer_if
  import result_buffer_pkg::*;
#(
  parameter int RESULT_WIDTH = RESULT_WIDTH_DEF
);
  logic [RESULT_WIDTH-1:0] result_data;
  logic                    result_wr_en;
  logic [RESULT_WIDTH-1:0] rd_data;
  logic                    rd_valid;
  logic                    rd_ready;
  logic                    rd_last;

  modport master (
    output result_data,
    output result_wr_en,
    output rd_ready,
    input  rd_data,
    input  rd_valid,
    input  rd_last
  );

  modport slave (
    input  result_data,
    input  result_wr_en,
    input  rd_ready,
    output rd_data,
    output rd_valid,
    output rd_last
  );
endinterface

// File: rtl/result_readback_buffer_ram.sv
// Simple dual-port entry RAM, registered read port.
// No reset on the array or read register so it maps to block RAM.
module result_buffer_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/result_readback_buffer.sv
// Result buffer: drop-on-full push side, FWFT valid/ready read side.
// RESULT_TIMESTAMP_EN appends a cycle timestamp word to every entry.
module result_readback_buffer
  import result_buffer_pkg::*;
#(
  parameter int DEPTH        = 64,
  parameter int RESULT_WIDTH = RESULT_WIDTH_DEF,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     init,
  result_readback_buffer_if.slave  bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_WIDTH-1:0]     drop_count,
  input  logic                     clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = entry_width(RESULT_WIDTH);

  rd_state_e state_q, state_d;

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;

  logic          out_vld;
  logic          last;
  logic          pop;
  logic          pop_last;
  logic          full;
  logic          push;
  logic          drop;
  logic          load;
  logic [LW-1:0] ram_cnt;
  logic [EW-1:0] wdata;
  logic [EW-1:0] ram_q;

  assign out_vld = (state_q != S_IDLE);
`ifdef RESULT_TIMESTAMP_EN
  assign last = (state_q == S_TS);
`else
  assign last = out_vld;
`endif

  assign pop      = !init && out_vld && bus.rd_ready;
  assign pop_last = pop && last;
  assign full     = (level_q == LW'(DEPTH));
  // Entries still in the RAM, excluding the one held at the output.
  assign ram_cnt  = level_q - LW'(out_vld);
  assign load     = !init && (ram_cnt != '0) && (!out_vld || pop_last);
  assign push     = !init && bus.result_wr_en && (!full || pop_last);
  assign drop     = !init && bus.result_wr_en && full && !pop_last;

`ifdef RESULT_TIMESTAMP_EN
  logic [RESULT_WIDTH-1:0] ts_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_q <= '0;
    end else if (init) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + RESULT_WIDTH'(1);
    end
  end

  assign wdata = {ts_q, bus.result_data};
`else
  assign wdata = bus.result_data;
`endif

  result_buffer_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (AW)
  ) u_ram (
    .clk     (clock),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .re_i    (load),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_q)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (load) state_d = S_DATA;
      end
      S_DATA: begin
`ifdef RESULT_TIMESTAMP_EN
        if (pop) state_d = S_TS;
`else
        if (pop) state_d = load ? S_DATA : S_IDLE;
`endif
      end
`ifdef RESULT_TIMESTAMP_EN
      S_TS: begin
        if (pop) state_d = load ? S_DATA : S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (init) state_d = S_IDLE;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (load) rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push, pop_last})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as a clear still counts.
    if (clear_overflow) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_d != '1) drop_d = drop_d + CNT_WIDTH'(1);
    end

    if (init) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      drop_d   = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    if (out_vld) bus.rd_data = ram_q[RESULT_WIDTH-1:0];
`ifdef RESULT_TIMESTAMP_EN
    if (state_q == S_TS) bus.rd_data = ram_q[EW-1:RESULT_WIDTH];
`endif
  end

  assign bus.rd_valid = out_vld;
  assign bus.rd_last  = last;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign drop_count   = drop_q;

endmodule
